// File: rtl/dnpcie_aurora_tx_arbiter_pkg.sv
// dnpcie_aurora_tx_arbiter_pkg: shared types, widths and helpers for the Aurora TX arbiter slice
package dnpcie_aurora_pkg;
  typedef enum logic [1:0] {IDLE, PASS, DRAIN} state_e;
  localparam int TX_DATA_W = 16;
  localparam int TX_KEEP_W = 2;
  localparam int DROP_CNT_W = 16;
  function automatic int clog2(input int n);
    int r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/dnpcie_aurora_tx_arbiter_if.sv
// dnpcie_aurora_tx_arbiter_if: NUM_SRC source streams plus the shared 16-bit TX stream
interface dnpcie_aurora_tx_arbiter_if import dnpcie_aurora_pkg::*; #(
  parameter int NUM_SRC = 4
);
  logic [TX_DATA_W*NUM_SRC-1:0] s_axis_tdata;
  logic [TX_KEEP_W*NUM_SRC-1:0] s_axis_tkeep;
  logic [NUM_SRC-1:0] s_axis_tvalid;
  logic [NUM_SRC-1:0] s_axis_tlast;
  logic [NUM_SRC-1:0] s_axis_tready;
  logic [TX_DATA_W-1:0] m_axis_tdata;
  logic [TX_KEEP_W-1:0] m_axis_tkeep;
  logic m_axis_tvalid;
  logic m_axis_tlast;
  logic m_axis_tready;
  modport master (
    input  s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast
  );
  modport slave (
    output s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast
  );
endinterface

// File: rtl/dnpcie_aurora_tx_arbiter_rr.sv
// dnpcie_rr_arbiter: combinational round-robin pick of the first request at or after i_ptr
module dnpcie_rr_arbiter import dnpcie_aurora_pkg::*; #(
  parameter int N = 4,
  localparam int IDX_W = clog2(N)
) (
  input  logic [N-1:0] i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0] o_gnt_oh,
  output logic [IDX_W-1:0] o_gnt_idx
);
  logic [IDX_W-1:0] w_j;
  // scan from farthest to nearest so the nearest requester is written last and wins
  always_comb begin
    o_gnt_oh = '0;
    o_gnt_idx = '0;
    w_j = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_j = IDX_W'((int'(i_ptr) + k) % N);
      if (i_req[w_j]) begin
        o_gnt_oh = '0;
        o_gnt_oh[w_j] = 1'b1;
        o_gnt_idx = w_j;
      end
    end
  end
endmodule

// File: rtl/dnpcie_aurora_tx_arbiter.sv
// dnpcie_aurora_tx_arbiter: packet-granular round-robin arbiter onto one Aurora 16-bit TX stream.
// Define DNPCIE_AURORA_TX_ARB_LEN_LIMIT_EN to cut packets at MAX_PKT_BEATS and flag len_err.
module dnpcie_aurora_tx_arbiter import dnpcie_aurora_pkg::*; #(
  parameter int NUM_SRC = 4,
  parameter int MAX_PKT_BEATS = 512,
  localparam int IDX_W = clog2(NUM_SRC)
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic channel_up,
  input  logic xoff,
  dnpcie_aurora_tx_arbiter_if.master axis,
  output logic [IDX_W-1:0] grant_id,
  output logic busy,
  output logic [DROP_CNT_W-1:0] drop_count,
  output logic len_err
);
  state_e r_state, w_nxt;
  logic [IDX_W-1:0] r_ptr, r_gid, w_win_idx;
  logic [NUM_SRC-1:0] w_win_oh;
  logic [DROP_CNT_W-1:0] r_drop;
  logic r_ch_up, r_no_cnt, w_start, w_vld, w_last, w_acc, w_at_lim, w_cut, w_drop, w_done;

  if (NUM_SRC < 2 || NUM_SRC > 8 || MAX_PKT_BEATS < 1) begin : g_bad_cfg
    $error("dnpcie_aurora_tx_arbiter: unsupported NUM_SRC or MAX_PKT_BEATS");
  end

  dnpcie_rr_arbiter #(.N(NUM_SRC)) u_rr (
    .i_req(axis.s_axis_tvalid),
    .i_ptr(r_ptr),
    .o_gnt_oh(w_win_oh),
    .o_gnt_idx(w_win_idx)
  );

  always_comb begin
    w_vld = 1'b0;
    w_last = 1'b0;
    axis.m_axis_tdata = '0;
    axis.m_axis_tkeep = '0;
    for (int i = 0; i < NUM_SRC; i++)
      if (IDX_W'(i) == r_gid) begin
        w_vld = axis.s_axis_tvalid[i];
        w_last = axis.s_axis_tlast[i];
        axis.m_axis_tdata = axis.s_axis_tdata[i*TX_DATA_W +: TX_DATA_W];
        axis.m_axis_tkeep = axis.s_axis_tkeep[i*TX_KEEP_W +: TX_KEEP_W];
      end
  end

  assign w_start = r_state == IDLE && channel_up && !xoff && |w_win_oh;
  assign w_acc = r_state == PASS && w_vld && axis.m_axis_tready;
  assign w_cut = w_acc && w_at_lim && !w_last;
  assign w_drop = r_state == DRAIN && w_vld && w_last && !r_no_cnt;
  assign w_done = r_state != IDLE && w_nxt == IDLE;
  assign axis.m_axis_tvalid = r_state == PASS && w_vld;
  assign axis.m_axis_tlast = w_last | w_at_lim;
  assign axis.s_axis_tready = r_state == PASS ? NUM_SRC'(axis.m_axis_tready) << r_gid :
                              r_state == DRAIN ? NUM_SRC'(1) << r_gid : '0;
  assign grant_id = r_gid;
  assign busy = r_state != IDLE;
  assign drop_count = r_drop;

  always_comb begin
    w_nxt = r_state;
    if (r_state == IDLE)
      w_nxt = w_start ? PASS : IDLE;
    else if (r_state == PASS)
      w_nxt = (w_acc && w_last) ? IDLE : (w_cut || !r_ch_up) ? DRAIN : PASS;
    else
      w_nxt = (w_vld && w_last) ? IDLE : DRAIN;
  end

  always_ff @(posedge aclk)
    if (!aresetn) begin
      r_state <= IDLE;
      r_ptr <= '0;
      r_gid <= '0;
      r_ch_up <= 1'b0;
      r_no_cnt <= 1'b0;
      r_drop <= '0;
    end else begin
      r_state <= w_nxt;
      r_ch_up <= channel_up;
      if (w_start) r_gid <= w_win_idx;
      if (w_done) r_ptr <= r_gid == IDX_W'(NUM_SRC - 1) ? '0 : r_gid + 1'b1;
      if (r_state == PASS) r_no_cnt <= w_cut;
      if (w_drop && r_drop != '1) r_drop <= r_drop + 1'b1;
    end

`ifdef DNPCIE_AURORA_TX_ARB_LEN_LIMIT_EN
  localparam int BW = clog2(MAX_PKT_BEATS + 1);
  logic [BW-1:0] r_beats;
  logic r_len_err;
  // tlast is forced for the whole life of the limit beat so it stays stable across backpressure
  assign w_at_lim = r_state == PASS && r_beats == BW'(MAX_PKT_BEATS - 1);
  assign len_err = r_len_err;
  always_ff @(posedge aclk)
    if (!aresetn) begin
      r_beats <= '0;
      r_len_err <= 1'b0;
    end else begin
      r_beats <= r_state == PASS ? r_beats + BW'(w_acc) : '0;
      r_len_err <= r_len_err | w_cut;
    end
`else
  assign w_at_lim = 1'b0;
  assign len_err = 1'b0;
`endif
endmodule
